// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing a byte-wide combinational ROM between the fetch and load ports.
// state | meaning: IDLE arbitrate/latch, READ one ROM byte per cycle, DONE ack granted port for one cycle.
module rom_arbiter #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_ack,
  output logic [31:0]           fetch_data,
  output logic                  fetch_illegal,
  input  logic                  load_req,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [1:0]            load_size,
  output logic                  load_ack,
  output logic [31:0]           load_data,
  output logic                  load_illegal,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [7:0]            rom_data,
  input  logic                  rom_illegal,
  output logic                  busy
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DONE} state_t;

  localparam logic ID_FETCH = 1'b0;
  localparam logic ID_LOAD  = 1'b1;

  state_t                state_q, state_d;
  logic                  id_q, id_d;
  logic                  last_q, last_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [1:0]            idx_q, idx_d;
  logic [1:0]            lidx_q, lidx_d;
  logic [31:0]           acc_q, acc_d;
  logic                  ill_q, ill_d;
  logic [31:0]           fetch_data_q, load_data_q;
  logic                  fetch_ill_q, load_ill_q;
  logic                  gid;
  logic                  fault;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    last_d  = last_q;
    base_d  = base_q;
    idx_d   = idx_q;
    lidx_d  = lidx_q;
    acc_d   = acc_q;
    ill_d   = ill_q;
    gid     = ID_FETCH;
    fault   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fetch_req || load_req) begin
          // Load wins only when alone, or on a tie when fetch was granted last.
          gid = load_req && (!fetch_req || (last_q == ID_FETCH));
          id_d = gid;
          if (gid == ID_LOAD) begin
            base_d = load_addr;
            case (load_size)
              2'd0:    lidx_d = 2'd0;
              2'd1:    lidx_d = 2'd1;
              2'd2:    lidx_d = 2'd3;
              default: lidx_d = 2'd0;
            endcase
            fault = (load_size == 2'd3)
                 || ((load_size == 2'd2) && (load_addr[1:0] != 2'b00))
                 || ((load_size == 2'd1) && load_addr[0]);
          end else begin
            base_d = fetch_addr;
            lidx_d = 2'd3;
            fault  = (fetch_addr[1:0] != 2'b00);
          end
          acc_d   = '0;
          ill_d   = fault;
          idx_d   = 2'd0;
          state_d = fault ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        acc_d[8*idx_q +: 8] = rom_data;
        ill_d = ill_q | rom_illegal;
        if (idx_q == lidx_q) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      S_DONE: begin
        last_d  = id_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_q         <= ID_FETCH;
      last_q       <= ID_LOAD;
      base_q       <= '0;
      idx_q        <= '0;
      lidx_q       <= '0;
      acc_q        <= '0;
      ill_q        <= 1'b0;
      fetch_data_q <= '0;
      fetch_ill_q  <= 1'b0;
      load_data_q  <= '0;
      load_ill_q   <= 1'b0;
    end else begin
      id_q   <= id_d;
      last_q <= last_d;
      base_q <= base_d;
      idx_q  <= idx_d;
      lidx_q <= lidx_d;
      acc_q  <= acc_d;
      ill_q  <= ill_d;
      // Result registers load on entry to DONE so they are valid alongside ack.
      if ((state_d == S_DONE) && (state_q != S_DONE)) begin
        if (id_d == ID_LOAD) begin
          load_data_q <= acc_d;
          load_ill_q  <= ill_d;
        end else begin
          fetch_data_q <= acc_d;
          fetch_ill_q  <= ill_d;
        end
      end
    end
  end

  always_comb begin
    rom_addr  = '0;
    fetch_ack = 1'b0;
    load_ack  = 1'b0;
    busy      = (state_q != S_IDLE);
    if (state_q == S_READ) begin
      rom_addr = base_q + {{(ADDR_WIDTH-2){1'b0}}, idx_q};
    end
    if (state_q == S_DONE) begin
      fetch_ack = (id_q == ID_FETCH);
      load_ack  = (id_q == ID_LOAD);
    end
  end

  assign fetch_data    = fetch_data_q;
  assign fetch_illegal = fetch_ill_q;
  assign load_data     = load_data_q;
  assign load_illegal  = load_ill_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter with a 256-byte ROM model; byte 0xFE and anything >= 0x100 flag illegal.
module tb_rom_arbiter;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_ack;
  logic [31:0]   fetch_data;
  logic          fetch_illegal;
  logic          load_req;
  logic [AW-1:0] load_addr;
  logic [1:0]    load_size;
  logic          load_ack;
  logic [31:0]   load_data;
  logic          load_illegal;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data;
  logic          rom_illegal;
  logic          busy;

  logic [7:0]  mem [0:255];
  int          checks = 0;
  int          errors = 0;
  int          fcyc, lcyc;
  logic [31:0] raddr [0:7];
  logic [31:0] rom_or;
  int          ackc  [0:2];
  logic        ackid [0:2];
  int          nack;
  logic        ack_seen;

  rom_arbiter #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack),
    .fetch_data(fetch_data), .fetch_illegal(fetch_illegal),
    .load_req(load_req), .load_addr(load_addr), .load_size(load_size),
    .load_ack(load_ack), .load_data(load_data), .load_illegal(load_illegal),
    .rom_addr(rom_addr), .rom_data(rom_data), .rom_illegal(rom_illegal),
    .busy(busy)
  );

  assign rom_data    = mem[rom_addr[7:0]];
  assign rom_illegal = (rom_addr >= 32'h100) || (rom_addr == 32'hFE);

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Raise the selected requests in an IDLE cycle (cycle 0) and drop each at its ack.
  task automatic run(input logic fen, input logic [31:0] fa,
                     input logic len, input logic [31:0] la, input logic [1:0] ls);
    fcyc = -1;
    lcyc = -1;
    rom_or = '0;
    for (int i = 0; i < 8; i++) raddr[i] = 'x;
    fetch_req = fen; fetch_addr = fa;
    load_req = len;  load_addr = la; load_size = ls;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (c <= 8) raddr[c-1] = rom_addr;
      rom_or = rom_or | rom_addr;
      if (fetch_ack) begin fcyc = c; fetch_req = 1'b0; end
      if (load_ack)  begin lcyc = c; load_req = 1'b0; end
      if (!fetch_req && !load_req) break;
    end
    fetch_req = 1'b0;
    load_req  = 1'b0;
    step();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'h13; mem[1] = 8'h00; mem[2] = 8'h50; mem[3] = 8'h00;
    mem[4] = 8'h11; mem[5] = 8'h22; mem[6] = 8'h33; mem[7] = 8'h44;
    mem[8] = 8'hEF; mem[9] = 8'hBE; mem[10] = 8'hAD; mem[11] = 8'hDE;
    mem[252] = 8'hAA; mem[253] = 8'hBB; mem[254] = 8'hCC; mem[255] = 8'hDD;

    rst = 1'b1;
    fetch_req = 1'b0; fetch_addr = '0;
    load_req = 1'b0;  load_addr = '0; load_size = 2'd0;
    step(); step();
    chk("rst_fetch_ack", 32'(fetch_ack), 32'd0);
    chk("rst_load_ack",  32'(load_ack),  32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_rom_addr",  rom_addr,       32'd0);
    chk("rst_fetch_data", fetch_data,    32'd0);
    chk("rst_load_data",  load_data,     32'd0);
    rst = 1'b0;
    step();

    // Single word fetch
    run(1'b1, 32'h0, 1'b0, 32'h0, 2'd0);
    chk("fetch0_lat",  32'(fcyc), 32'd5);
    chk("fetch0_data", fetch_data, 32'h00500013);
    chk("fetch0_ill",  32'(fetch_illegal), 32'd0);
    chk("fetch0_ra0",  raddr[0], 32'd0);
    chk("fetch0_ra1",  raddr[1], 32'd1);
    chk("fetch0_ra2",  raddr[2], 32'd2);
    chk("fetch0_ra3",  raddr[3], 32'd3);
    chk("fetch0_ra_done", raddr[4], 32'd0);
    chk("fetch0_no_load_ack", 32'(lcyc), 32'hFFFF_FFFF);

    // Byte and halfword loads
    mem[3] = 8'hF0;
    run(1'b0, 32'h0, 1'b1, 32'h3, 2'd0);
    chk("lbyte_lat",  32'(lcyc), 32'd2);
    chk("lbyte_data", load_data, 32'h000000F0);
    chk("lbyte_ill",  32'(load_illegal), 32'd0);
    run(1'b0, 32'h0, 1'b1, 32'h2, 2'd1);
    chk("lhalf_lat",  32'(lcyc), 32'd3);
    chk("lhalf_data", load_data, 32'h0000F050);
    chk("lhalf_fetch_hold", fetch_data, 32'h00500013);

    // Both held high: round-robin alternation, fetch first
    nack = 0;
    fetch_req = 1'b1; fetch_addr = 32'h4;
    load_req = 1'b1;  load_addr = 32'h8; load_size = 2'd2;
    for (int c = 1; c <= 30 && nack < 3; c++) begin
      step();
      if (fetch_ack && nack < 3) begin ackc[nack] = c; ackid[nack] = 1'b0; nack++; end
      if (load_ack && nack < 3)  begin ackc[nack] = c; ackid[nack] = 1'b1; nack++; end
    end
    fetch_req = 1'b0;
    load_req  = 1'b0;
    step();
    chk("rr_nack",   32'(nack), 32'd3);
    chk("rr_c0",     32'(ackc[0]), 32'd5);
    chk("rr_id0",    32'(ackid[0]), 32'd0);
    chk("rr_c1",     32'(ackc[1]), 32'd11);
    chk("rr_id1",    32'(ackid[1]), 32'd1);
    chk("rr_c2",     32'(ackc[2]), 32'd17);
    chk("rr_id2",    32'(ackid[2]), 32'd0);
    chk("rr_fetch_data", fetch_data, 32'h44332211);
    chk("rr_load_data",  load_data,  32'hDEADBEEF);

    // Out-of-range byte inside a word load
    run(1'b0, 32'h0, 1'b1, 32'hFC, 2'd2);
    chk("oor_lat",  32'(lcyc), 32'd5);
    chk("oor_data", load_data, 32'hDDCCBBAA);
    chk("oor_ill",  32'(load_illegal), 32'd1);

    // Faults: one-cycle ack, no ROM traffic
    run(1'b0, 32'h0, 1'b1, 32'h1, 2'd1);
    chk("flh_lat",  32'(lcyc), 32'd1);
    chk("flh_ill",  32'(load_illegal), 32'd1);
    chk("flh_data", load_data, 32'd0);
    chk("flh_rom",  rom_or, 32'd0);
    run(1'b0, 32'h0, 1'b1, 32'h0, 2'd3);
    chk("fsz3_lat", 32'(lcyc), 32'd1);
    chk("fsz3_ill", 32'(load_illegal), 32'd1);
    chk("fsz3_rom", rom_or, 32'd0);
    run(1'b1, 32'h2, 1'b0, 32'h0, 2'd0);
    chk("ffe_lat",  32'(fcyc), 32'd1);
    chk("ffe_ill",  32'(fetch_illegal), 32'd1);
    chk("ffe_data", fetch_data, 32'd0);
    chk("ffe_rom",  rom_or, 32'd0);

    // Reset in cycle 2 of a word fetch
    fetch_req = 1'b1; fetch_addr = 32'h4;
    step(); step();
    rst = 1'b1;
    fetch_req = 1'b0;
    step();
    rst = 1'b0;
    chk("mrst_busy",       32'(busy), 32'd0);
    chk("mrst_rom_addr",   rom_addr, 32'd0);
    chk("mrst_fetch_ack",  32'(fetch_ack), 32'd0);
    chk("mrst_fetch_ill",  32'(fetch_illegal), 32'd0);
    chk("mrst_load_data",  load_data, 32'd0);
    chk("mrst_load_ill",   32'(load_illegal), 32'd0);
    ack_seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      ack_seen = ack_seen | fetch_ack | load_ack;
    end
    chk("mrst_no_ack", 32'(ack_seen), 32'd0);

    // Re-issue with a tie: fetch wins after reset
    run(1'b1, 32'h4, 1'b1, 32'h3, 2'd0);
    chk("re_fetch_lat",  32'(fcyc), 32'd5);
    chk("re_load_lat",   32'(lcyc), 32'd8);
    chk("re_fetch_data", fetch_data, 32'h44332211);
    chk("re_load_data",  load_data,  32'h000000F0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
